// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one registered memory port between the IF
// (instruction fetch) and MEM (load/store) pipeline stages.
// Each access runs IDLE -> BUSY_x -> DONE -> IDLE, so at most one access
// completes every three cycles. Data requests win ties. Optional feature:
// define MEM_ARB_FAIRNESS_EN so that IF is granted after two data grants
// in a row were made while it was waiting.
module mem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ireq,
    input  logic [AW-1:0] iaddr,
    output logic          iready,
    output logic [DW-1:0] irdata,
    input  logic          dreq,
    input  logic          dwe,
    input  logic [AW-1:0] daddr,
    input  logic [DW-1:0] dwdata,
    output logic          dready,
    output logic [DW-1:0] drdata,
    output logic          mreq,
    output logic          mwe,
    output logic [AW-1:0] maddr,
    output logic [DW-1:0] mwdata,
    input  logic [DW-1:0] mrdata,
    input  logic          mready,
    output logic          stallF,
    output logic          stallM
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

    state_t        state, state_nx;
    logic          mreq_nx, mwe_nx, iready_nx, dready_nx;
    logic [AW-1:0] maddr_nx;
    logic [DW-1:0] mwdata_nx, irdata_nx, drdata_nx;
    logic          prefer_if;
    logic          grant_i, grant_d;

`ifdef MEM_ARB_FAIRNESS_EN
    logic [1:0] fair_cnt, fair_cnt_nx;

    // IF wins a tie once two data grants in a row went by while it waited
    assign prefer_if = (fair_cnt == 2'd2);

    // Starvation count: clears on an IF grant or on an uncontested data grant
    always_comb begin
        fair_cnt_nx = fair_cnt;
        if (grant_i) begin
            fair_cnt_nx = 2'd0;
        end else if (grant_d) begin
            if (!ireq)
                fair_cnt_nx = 2'd0;
            else if (fair_cnt != 2'd3)
                fair_cnt_nx = fair_cnt + 2'd1;
        end
    end

    // Starvation counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            fair_cnt <= 2'd0;
        else
            fair_cnt <= fair_cnt_nx;
    end
`else
    assign prefer_if = 1'b0;
`endif

    // Arbitration happens only in IDLE; DONE deliberately skips it
    assign grant_d = (state == IDLE) && dreq && !(ireq && prefer_if);
    assign grant_i = (state == IDLE) && ireq && !grant_d;

    // Hazard-unit stalls: a request is pending until its ready pulse
    assign stallF = ireq & ~iready;
    assign stallM = dreq & ~dready;

    // Next-state and next-output logic; memory-side registers hold by default
    always_comb begin
        state_nx  = state;
        mreq_nx   = mreq;
        mwe_nx    = mwe;
        maddr_nx  = maddr;
        mwdata_nx = mwdata;
        iready_nx = 1'b0;
        dready_nx = 1'b0;
        irdata_nx = irdata;
        drdata_nx = drdata;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nx  = BUSY_D;
                    mreq_nx   = 1'b1;
                    mwe_nx    = dwe;
                    maddr_nx  = daddr;
                    mwdata_nx = dwdata;
                end else if (grant_i) begin
                    state_nx  = BUSY_I;
                    mreq_nx   = 1'b1;
                    mwe_nx    = 1'b0;
                    maddr_nx  = iaddr;
                    mwdata_nx = '0;
                end
            end
            BUSY_I: begin
                if (mready) begin
                    state_nx  = DONE;
                    mreq_nx   = 1'b0;
                    mwe_nx    = 1'b0;
                    iready_nx = 1'b1;
                    irdata_nx = mrdata;
                end
            end
            BUSY_D: begin
                if (mready) begin
                    state_nx  = DONE;
                    mreq_nx   = 1'b0;
                    mwe_nx    = 1'b0;
                    dready_nx = 1'b1;
                    // stores leave the last load value in place
                    if (!mwe)
                        drdata_nx = mrdata;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any access in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            mreq   <= 1'b0;
            mwe    <= 1'b0;
            maddr  <= '0;
            mwdata <= '0;
            iready <= 1'b0;
            dready <= 1'b0;
            irdata <= '0;
            drdata <= '0;
        end else begin
            state  <= state_nx;
            mreq   <= mreq_nx;
            mwe    <= mwe_nx;
            maddr  <= maddr_nx;
            mwdata <= mwdata_nx;
            iready <= iready_nx;
            dready <= dready_nx;
            irdata <= irdata_nx;
            drdata <= drdata_nx;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter. Expected grants
// and read results are queued as requests are issued and checked as the
// memory port and ready pulses appear. Honours MEM_ARB_FAIRNESS_EN.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          ireq;
    logic [AW-1:0] iaddr;
    logic          iready;
    logic [DW-1:0] irdata;
    logic          dreq;
    logic          dwe;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dwdata;
    logic          dready;
    logic [DW-1:0] drdata;
    logic          mreq;
    logic          mwe;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mwdata;
    logic [DW-1:0] mrdata;
    logic          mready;
    logic          stallF;
    logic          stallM;

    mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .ireq(ireq), .iaddr(iaddr), .iready(iready), .irdata(irdata),
        .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata),
        .dready(dready), .drdata(drdata),
        .mreq(mreq), .mwe(mwe), .maddr(maddr), .mwdata(mwdata),
        .mrdata(mrdata), .mready(mready),
        .stallF(stallF), .stallM(stallM)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    typedef struct {
        bit          we;
        logic [31:0] rdata;
    } dexp_t;

    txn_t        exp_grant[$];
    logic [31:0] exp_i[$];
    dexp_t       exp_d[$];

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // memory model: contents, per-address wait states, optional stray mready
    logic [31:0] mem[logic [31:0]];
    int          addr_wait[logic [31:0]];
    bit          spurious = 1'b0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a))
            return mem[a];
        return {~a[15:0], a[15:0]};
    endfunction

    initial begin
        int wcnt;
        int wlim;
        wcnt   = 0;
        mready = 1'b0;
        mrdata = '0;
        forever begin
            @(negedge clk);
            if (mreq && reset) begin
                wlim = addr_wait.exists(maddr) ? addr_wait[maddr] : 0;
                if (wcnt >= wlim) begin
                    mready = 1'b1;
                    if (mwe)
                        mem[maddr] = mwdata;
                    else
                        mrdata = mem_rd(maddr);
                end else begin
                    mready = 1'b0;
                    mrdata = $urandom;
                end
                wcnt++;
            end else begin
                wcnt   = 0;
                mready = spurious;
                mrdata = $urandom;
            end
        end
    end

    // monitor / scoreboard
    logic        mreq_q = 1'b0;
    txn_t        cur;
    int          n_iready = 0;
    int          n_dready = 0;
    int          last_grant_cyc = -1;
    logic [31:0] last_irdata = '0;
    logic [31:0] last_drdata = '0;

    initial begin
        dexp_t de;
        logic [31:0] ie;
        forever begin
            @(negedge clk);
            #1;
            if (!reset) begin
                last_irdata = '0;
                last_drdata = '0;
            end
            check_val("stallF", 64'(stallF), 64'(ireq & ~iready));
            check_val("stallM", 64'(stallM), 64'(dreq & ~dready));
            check_val("ready_excl", 64'(iready & dready), 64'(0));
            if (mreq && !mreq_q) begin
                last_grant_cyc = cyc;
                if (exp_grant.size() == 0) begin
                    check_val("grant_unexpected", 64'(1), 64'(0));
                end else begin
                    cur = exp_grant.pop_front();
                    check_val("grant_maddr", 64'(maddr), 64'(cur.addr));
                    check_val("grant_mwe", 64'(mwe), 64'(cur.we));
                    check_val("grant_mwdata", 64'(mwdata), 64'(cur.wdata));
                end
            end else if (mreq) begin
                check_val("hold_maddr", 64'(maddr), 64'(cur.addr));
                check_val("hold_mwe", 64'(mwe), 64'(cur.we));
                check_val("hold_mwdata", 64'(mwdata), 64'(cur.wdata));
            end
            mreq_q = mreq;

            if (iready) begin
                n_iready++;
                if (exp_i.size() == 0) begin
                    check_val("iready_unexpected", 64'(1), 64'(0));
                end else begin
                    ie = exp_i.pop_front();
                    check_val("irdata", 64'(irdata), 64'(ie));
                end
                last_irdata = irdata;
            end else begin
                check_val("irdata_hold", 64'(irdata), 64'(last_irdata));
            end

            if (dready) begin
                n_dready++;
                if (exp_d.size() == 0) begin
                    check_val("dready_unexpected", 64'(1), 64'(0));
                end else begin
                    de = exp_d.pop_front();
                    if (de.we)
                        check_val("drdata_store", 64'(drdata), 64'(last_drdata));
                    else
                        check_val("drdata_load", 64'(drdata), 64'(de.rdata));
                end
                last_drdata = drdata;
            end else begin
                check_val("drdata_hold", 64'(drdata), 64'(last_drdata));
            end
        end
    end

    // IF requester: hold ireq until iready, drop on the ready cycle
    task automatic if_fetch(input logic [31:0] a, output int done_cyc);
        bit done;
        done     = 1'b0;
        done_cyc = -1;
        ireq     = 1'b1;
        iaddr    = a;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            if (iready) begin
                done     = 1'b1;
                done_cyc = cyc;
                ireq     = 1'b0;
            end
        end
        if (!done) begin
            check_val("if_timeout", 64'(1), 64'(0));
            ireq = 1'b0;
        end
    endtask

    // MEM requester; scramble perturbs inputs after the grant
    task automatic mem_access(input bit we, input logic [31:0] a, input logic [31:0] wd,
                              input bit scramble, output int done_cyc);
        bit done;
        done     = 1'b0;
        done_cyc = -1;
        dreq     = 1'b1;
        dwe      = we;
        daddr    = a;
        dwdata   = wd;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            if (dready) begin
                done     = 1'b1;
                done_cyc = cyc;
                dreq     = 1'b0;
            end else if (scramble) begin
                daddr  = $urandom;
                dwdata = $urandom;
                dwe    = ~we;
            end
        end
        if (!done) begin
            check_val("d_timeout", 64'(1), 64'(0));
            dreq = 1'b0;
        end
    endtask

    int req_cyc, i_done, d_done, d1_done, d2_done, d3_done;
    int nir, ndr, rst_cyc;

    initial begin
        reset  = 1'b0;
        ireq   = 1'b0;
        iaddr  = '0;
        dreq   = 1'b0;
        dwe    = 1'b0;
        daddr  = '0;
        dwdata = '0;

        // reset state
        repeat (2) @(negedge clk);
        check_val("rst_mreq", 64'(mreq), 64'(0));
        check_val("rst_mwe", 64'(mwe), 64'(0));
        check_val("rst_maddr", 64'(maddr), 64'(0));
        check_val("rst_mwdata", 64'(mwdata), 64'(0));
        check_val("rst_iready", 64'(iready), 64'(0));
        check_val("rst_dready", 64'(dready), 64'(0));
        check_val("rst_irdata", 64'(irdata), 64'(0));
        check_val("rst_drdata", 64'(drdata), 64'(0));
        #2 reset = 1'b1;
        @(negedge clk);

        // stray mready while idle must be ignored
        nir = n_iready;
        ndr = n_dready;
        spurious = 1'b1;
        repeat (4) @(negedge clk);
        spurious = 1'b0;
        @(negedge clk);
        check_val("spurious_iready", 64'(n_iready), 64'(nir));
        check_val("spurious_dready", 64'(n_dready), 64'(ndr));
        check_val("spurious_mreq", 64'(mreq), 64'(0));

        // single fetch, zero wait
        mem[32'h40] = 32'h2002_0005;
        exp_grant.push_back('{is_d: 1'b0, we: 1'b0, addr: 32'h40, wdata: 32'h0});
        exp_i.push_back(32'h2002_0005);
        req_cyc = cyc;
        if_fetch(32'h40, i_done);
        check_val("fetch_grant_cyc", 64'(last_grant_cyc), 64'(req_cyc + 1));
        check_val("fetch_ready_cyc", 64'(i_done), 64'(req_cyc + 2));
        @(negedge clk);
        check_val("fetch_idle_mreq", 64'(mreq), 64'(0));
        check_val("fetch_idle_iready", 64'(iready), 64'(0));
        repeat (2) @(negedge clk);

        // store then load back
        exp_grant.push_back('{is_d: 1'b1, we: 1'b1, addr: 32'd84, wdata: 32'd7});
        exp_d.push_back('{we: 1'b1, rdata: 32'h0});
        mem_access(1'b1, 32'd84, 32'd7, 1'b0, d_done);
        exp_grant.push_back('{is_d: 1'b1, we: 1'b0, addr: 32'd84, wdata: 32'h1234});
        exp_d.push_back('{we: 1'b0, rdata: 32'd7});
        mem_access(1'b0, 32'd84, 32'h1234, 1'b0, d_done);
        repeat (2) @(negedge clk);

        // collision: data first with 3 wait states, then IF
        mem[32'd80]      = 32'hCAFE_0080;
        addr_wait[32'd80] = 3;
        exp_grant.push_back('{is_d: 1'b1, we: 1'b0, addr: 32'd80, wdata: 32'h55});
        exp_grant.push_back('{is_d: 1'b0, we: 1'b0, addr: 32'h44, wdata: 32'h0});
        exp_d.push_back('{we: 1'b0, rdata: 32'hCAFE_0080});
        exp_i.push_back(32'hFFBB_0044);
        req_cyc = cyc;
        fork
            if_fetch(32'h44, i_done);
            mem_access(1'b0, 32'd80, 32'h55, 1'b1, d_done);
        join
        check_val("coll_dready_cyc", 64'(d_done), 64'(req_cyc + 5));
        check_val("coll_iready_cyc", 64'(i_done), 64'(req_cyc + 8));
        dreq = 1'b0;
        repeat (2) @(negedge clk);

        // fairness: ireq held, dreq re-asserted back-to-back
`ifdef MEM_ARB_FAIRNESS_EN
        exp_grant.push_back('{is_d: 1'b1, we: 1'b0, addr: 32'h200, wdata: 32'h0});
        exp_grant.push_back('{is_d: 1'b1, we: 1'b0, addr: 32'h204, wdata: 32'h0});
        exp_grant.push_back('{is_d: 1'b0, we: 1'b0, addr: 32'h48, wdata: 32'h0});
        exp_grant.push_back('{is_d: 1'b1, we: 1'b0, addr: 32'h208, wdata: 32'h0});
`else
        exp_grant.push_back('{is_d: 1'b1, we: 1'b0, addr: 32'h200, wdata: 32'h0});
        exp_grant.push_back('{is_d: 1'b1, we: 1'b0, addr: 32'h204, wdata: 32'h0});
        exp_grant.push_back('{is_d: 1'b1, we: 1'b0, addr: 32'h208, wdata: 32'h0});
        exp_grant.push_back('{is_d: 1'b0, we: 1'b0, addr: 32'h48, wdata: 32'h0});
`endif
        exp_i.push_back(mem_rd(32'h48));
        exp_d.push_back('{we: 1'b0, rdata: mem_rd(32'h200)});
        exp_d.push_back('{we: 1'b0, rdata: mem_rd(32'h204)});
        exp_d.push_back('{we: 1'b0, rdata: mem_rd(32'h208)});
        fork
            if_fetch(32'h48, i_done);
            begin
                mem_access(1'b0, 32'h200, 32'h0, 1'b0, d1_done);
                mem_access(1'b0, 32'h204, 32'h0, 1'b0, d2_done);
                mem_access(1'b0, 32'h208, 32'h0, 1'b0, d3_done);
            end
        join
        check_val("fair_d2_before_if", 64'(d2_done < i_done), 64'(1));
`ifdef MEM_ARB_FAIRNESS_EN
        check_val("fair_if_before_d3", 64'(i_done < d3_done), 64'(1));
`else
        check_val("strict_if_after_d3", 64'(i_done > d3_done), 64'(1));
`endif
        repeat (2) @(negedge clk);

        // reset in the middle of a data access
        addr_wait[32'h100] = 20;
        exp_grant.push_back('{is_d: 1'b1, we: 1'b0, addr: 32'h100, wdata: 32'h0});
        exp_grant.push_back('{is_d: 1'b1, we: 1'b0, addr: 32'h100, wdata: 32'h0});
        exp_d.push_back('{we: 1'b0, rdata: mem_rd(32'h100)});
        fork
            mem_access(1'b0, 32'h100, 32'h0, 1'b0, d_done);
            begin
                repeat (3) @(negedge clk);
                check_val("rst_busy_mreq_pre", 64'(mreq), 64'(1));
                #2 reset = 1'b0;
                #1;
                rst_cyc = cyc;
                check_val("rst_busy_mreq", 64'(mreq), 64'(0));
                check_val("rst_busy_mwe", 64'(mwe), 64'(0));
                check_val("rst_busy_dready", 64'(dready), 64'(0));
                addr_wait[32'h100] = 0;
                repeat (2) @(negedge clk);
                #2 reset = 1'b1;
            end
        join
        check_val("rst_regrant", 64'(last_grant_cyc > rst_cyc), 64'(1));
        check_val("rst_done", 64'(d_done > rst_cyc), 64'(1));

        repeat (4) @(negedge clk);
        check_val("grant_q_empty", 64'(exp_grant.size()), 64'(0));
        check_val("iexp_q_empty", 64'(exp_i.size()), 64'(0));
        check_val("dexp_q_empty", 64'(exp_d.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // overall time bound
    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
